// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle controller with memory wait states.
//   state_t    : FSM state encoding
//   cond_t     : ARM condition-code field encoding
//   ALU_*      : ALUControl output codes
//   CMD_*      : data-processing cmd field (funct[4:1]) values
//   OP_*       : instruction op field values
//   alu_decode : maps a DP cmd to its ALUControl code, writeback and CMP flags
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC,
        COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT,
        COND_GT, COND_LE, COND_AL, COND_NV
    } cond_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_ORR = 4'b0110;
    localparam logic [3:0] ALU_EOR = 4'b1000;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       writeback;
        logic       is_cmp;
    } alu_dec_t;

    // Unsupported cmds fall back to ADD with no writeback so the FSM simply
    // returns to FETCH without touching the register file.
    function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
        alu_dec_t d;
        d = '{alu_ctrl: ALU_ADD, writeback: 1'b0, is_cmp: 1'b0};
        case (cmd)
            CMD_ADD: d = '{alu_ctrl: ALU_ADD, writeback: 1'b1, is_cmp: 1'b0};
            CMD_SUB: d = '{alu_ctrl: ALU_SUB, writeback: 1'b1, is_cmp: 1'b0};
            CMD_AND: d = '{alu_ctrl: ALU_AND, writeback: 1'b1, is_cmp: 1'b0};
            CMD_ORR: d = '{alu_ctrl: ALU_ORR, writeback: 1'b1, is_cmp: 1'b0};
            CMD_EOR: d = '{alu_ctrl: ALU_EOR, writeback: 1'b1, is_cmp: 1'b0};
            CMD_CMP: d = '{alu_ctrl: ALU_SUB, writeback: 1'b0, is_cmp: 1'b1};
            default: d = '{alu_ctrl: ALU_ADD, writeback: 1'b0, is_cmp: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cond_unit.sv
// -----------------------------------------------------------------------------
// cond_unit
// Holds the NZCV flags register and evaluates the instruction condition field
// against the stored flags.
//   clk, reset : clock, async active-high reset (clears flags)
//   cond       : instruction condition field
//   alu_flags  : NZCV from the ALU in the current cycle
//   flag_req   : controller wants the flags updated at the end of this cycle
//   cond_ex    : condition passes against stored flags
//   flags      : stored NZCV
// -----------------------------------------------------------------------------
module cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_req,
    output logic       cond_ex,
    output logic [3:0] flags
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    // A failed condition also blocks the flag update.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (flag_req && cond_ex) begin
            flags <= alu_flags;
        end
    end

    // NOTE: cond_ex gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cond_ex = 1'b0;
        case (cond_t'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller_ws.sv
// -----------------------------------------------------------------------------
// mc_controller_ws
// Multicycle ARM-subset controller with memory wait-state support.
// Parameters:
//   MEM_HANDSHAKE : 0 = fixed-latency memory, 1 = MemReady handshake
//   MEM_WAIT      : extra wait cycles per access when MEM_HANDSHAKE=0 (0..15)
// Ports:
//   clk, reset         : clock, async active-high reset
//   Instr[19:0]        : instruction bits [31:12]
//   ALUFlags           : NZCV from the ALU this cycle
//   MemReady           : memory done (handshake mode only)
//   MemReq             : a memory access is in progress
//   PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc : datapath strobes/selects
//   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  : datapath selects
//   ALUControl         : ALU operation
// -----------------------------------------------------------------------------
module mc_controller_ws
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 0,
    parameter int MEM_WAIT      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        MemReq,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic       unused_instr;

    assign cond  = Instr[19:16];
    assign op    = Instr[15:14];
    assign funct = Instr[13:8];
    // Rd and the low operand bits are datapath concerns only.
    assign unused_instr = ^Instr[7:0];

    assign ImmSrc = op;
    assign RegSrc = {op == OP_MEM, op == OP_BR};

    state_t     state, state_next;
    logic [3:0] wait_cnt;
    logic       mem_state;
    logic       mem_ok;
    logic       cond_ex;
    logic       flag_req;
    alu_dec_t   dec;

    assign dec       = alu_decode(funct[4:1]);
    assign mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    assign mem_ok    = (MEM_HANDSHAKE != 0) ? MemReady : (wait_cnt == 4'(MEM_WAIT));

    cond_unit u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .alu_flags (ALUFlags),
        .flag_req  (flag_req),
        .cond_ex   (cond_ex),
        .flags     ()
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // The counter only runs while a memory state is stalled; any completed
    // access or non-memory state leaves it at zero, so every memory state is
    // entered with a fresh count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (mem_state && !mem_ok) begin
            wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    always_comb begin
        state_next = state;
        MemReq     = 1'b0;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        flag_req   = 1'b0;

        case (state)
            FETCH: begin
                MemReq    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ok) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    OP_MEM:  state_next = MEMADR;
                    OP_BR:   state_next = BRANCH;
                    OP_DP:   state_next = funct[5] ? EXECI : EXECR;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                state_next = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ok) begin
                    state_next = MEMWB;
                end
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = cond_ex;
                state_next = FETCH;
            end
            MEMWRITE: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ok) begin
                    MemWrite   = cond_ex;
                    state_next = FETCH;
                end
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
                ALUControl = dec.alu_ctrl;
                flag_req   = funct[0] | dec.is_cmp;
                state_next = dec.writeback ? ALUWB : FETCH;
            end
            ALUWB: begin
                RegWrite   = cond_ex;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                PCWrite    = cond_ex;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

endmodule

// File: doc/mc_controller_ws.md
MC_CONTROLLER_WS -- requirements
Module: mc_controller_ws

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 0; 0 = fixed-latency memory, 1 = MemReady handshake.
REQ-002 SHALL have parameter MEM_WAIT, default 0, range 0..15; extra wait cycles per memory access when MEM_HANDSHAKE=0.
REQ-003 SHALL have one clock and an asynchronous, active-high reset:
  clk  in  1  rising-edge clock
  reset  in  1  async active-high reset
REQ-004 SHALL have these ports:
  Instr  in  20  instruction bits [31:12]: cond[31:28], op[27:26], funct[25:20], Rd[15:12]
  ALUFlags  in  4  NZCV from ALU, current cycle
  MemReady  in  1  memory done; used only when MEM_HANDSHAKE=1
  MemReq  out  1  memory access in progress
  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc  out  1 each  datapath strobes/selects
  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  out  2 each  datapath selects
  ALUControl  out  4  ALU operation

Function
REQ-005 SHALL implement FSM states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
REQ-006 SHALL define mem_ok = MemReady if MEM_HANDSHAKE=1, else (wait_cnt == MEM_WAIT); wait_cnt clears on entry to every memory state and increments while mem_ok=0.
REQ-007 SHALL make FETCH, MEMREAD and MEMWRITE memory states: MemReq=1, AdrSrc=0 in FETCH, AdrSrc=1 otherwise; the FSM holds in the state while mem_ok=0.
REQ-008 FETCH SHALL drive ALUSrcA=01, ALUSrcB=10, ALUControl=0000, ResultSrc=10; IRWrite=PCWrite=1 only in the mem_ok cycle; then go to DECODE.
REQ-009 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10, ALUControl=0000, ResultSrc=10, with no strobes; next state: op=01 -> MEMADR; op=10 -> BRANCH; op=00 with funct[5]=1 -> EXECI, else EXECR; op=11 -> FETCH.
REQ-010 MEMADR SHALL drive ALUSrcA=00, ALUSrcB=01, ALUControl=0000; next MEMREAD if funct[0]=1, else MEMWRITE.
REQ-011 MEMREAD SHALL drive ResultSrc=00 and go to MEMWB on mem_ok; MEMWB SHALL drive ResultSrc=01 and RegWrite=CondEx, then go to FETCH.
REQ-012 MEMWRITE SHALL drive ResultSrc=00 and MemWrite=CondEx only in the mem_ok cycle, then go to FETCH.
REQ-013 EXECR SHALL drive ALUSrcA=00, ALUSrcB=00; EXECI SHALL drive ALUSrcA=00, ALUSrcB=01; both then go to ALUWB, or to FETCH for CMP or an unsupported cmd.
REQ-014 ALUWB SHALL drive ResultSrc=00 and RegWrite=CondEx, then go to FETCH.
REQ-015 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=01, ALUControl=0000, ResultSrc=10 and PCWrite=CondEx, then go to FETCH.
REQ-016 ALUControl in EXECR/EXECI SHALL decode funct[4:1] as follows: ADD(0100)->0000, SUB(0010)->0010, AND(0000)->0100, ORR(1100)->0110, EOR(0001)->1000, CMP(1010)->0010; all other codes -> 0000 with no writeback.
REQ-017 ImmSrc SHALL equal op; RegSrc[0] SHALL be (op==10); RegSrc[1] SHALL be (op==01); all three are combinational in every state.
REQ-018 CondEx SHALL evaluate all 15 ARM conditions (0000..1110) against the stored flags; 1111 SHALL evaluate false.
REQ-019 The flags register SHALL load ALUFlags at the end of EXECR/EXECI when (funct[0]=1 or cmd=CMP) and CondEx=1.
REQ-020 A failed condition SHALL NOT change the FSM path; it SHALL suppress only RegWrite, MemWrite, branch PCWrite and the flag update.
REQ-021 With MEM_HANDSHAKE=0 and MEM_WAIT=0, cycle behaviour SHALL equal a zero-wait controller: fetch 1 cycle, DP 4 cycles, LDR 5 cycles, STR 4 cycles, B 3 cycles.
REQ-022 With MEM_HANDSHAKE=1, MemReady asserted in the entry cycle SHALL complete the access in that cycle.

Reset
REQ-023 Reset SHALL asynchronously force state=FETCH, flags=0000 and wait_cnt=0; outputs then match the FETCH values (PCWrite/IRWrite follow mem_ok).
REQ-024 Reset mid-access SHALL abandon the access with no MemWrite or RegWrite.

Structure
REQ-025 The state encoding, ALUControl codes and condition codes SHALL live in the shared package mc_ctrl_pkg.
REQ-026 Condition evaluation and the flags register SHALL form the sub-module cond_unit.

Verification
REQ-027 Defaults, SUB reg E04F000F: -> FETCH/DECODE/EXECR with ALUControl=0010, then ALUWB with RegWrite=1.
REQ-028 MEM_WAIT=3, LDR E5902060: -> FETCH holds 4 cycles with IRWrite=0 for the first 3; MEMREAD holds 4 cycles with AdrSrc=1; total 11 cycles.
REQ-029 MEM_HANDSHAKE=1, STR E5837054, MemReady low 2 cycles in MEMWRITE: -> MemWrite=1 only in the third cycle.
REQ-030 CMP sets Z (ALUFlags=0100), then BNE 1A000001: -> BRANCH with PCWrite=0, and RegWrite=0 throughout.
REQ-031 Reset asserted in MEMREAD of an LDR: -> next state FETCH, flags=0000, and no RegWrite.
